// File: rtl/demux_stream.sv
// rtl/demux_stream.sv - 1-to-4 valid/ready stream demux with one-entry holding register per channel.
// Optional per-channel drain counters are enabled by defining DEMUX_STREAM_CNT_EN.
module demux_stream #(
    parameter int WIDTH = 8
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic [WIDTH-1:0]   data_i,
    input  logic [1:0]         sel_i,
    input  logic               valid_i,
    output logic               ready_o,
    output logic [4*WIDTH-1:0] q_o,
    output logic [3:0]         valid_o,
    input  logic [3:0]         ready_i
`ifdef DEMUX_STREAM_CNT_EN
    ,
    input  logic               cnt_clr_i,
    output logic [31:0]        cnt_o
`endif
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } ch_state_t;

    ch_state_t          r_state [4];
    logic [4*WIDTH-1:0] r_q;
    logic               w_accept;
    logic [3:0]         w_load;
    logic [3:0]         w_drain;

    // A full channel can still take a beat when it drains in the same cycle.
    assign ready_o  = (r_state[sel_i] == ST_EMPTY) | ready_i[sel_i];
    assign w_accept = valid_i & ready_o;
    assign q_o      = r_q;

    always_comb begin
        w_load  = '0;
        w_drain = '0;
        valid_o = '0;
        for (int k = 0; k < 4; k++) begin
            w_load[k]  = w_accept && (sel_i == 2'(k));
            valid_o[k] = (r_state[k] == ST_FULL);
            w_drain[k] = (r_state[k] == ST_FULL) && ready_i[k];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 4; k++) begin
                r_state[k] <= ST_EMPTY;
            end
            r_q <= '0;
        end else begin
            for (int k = 0; k < 4; k++) begin
                case (r_state[k])
                    ST_EMPTY: begin
                        if (w_load[k]) begin
                            r_state[k]               <= ST_FULL;
                            r_q[k*WIDTH +: WIDTH]    <= data_i;
                        end
                    end
                    ST_FULL: begin
                        // Slice keeps its last value after draining.
                        if (w_load[k]) begin
                            r_q[k*WIDTH +: WIDTH]    <= data_i;
                        end else if (w_drain[k]) begin
                            r_state[k]               <= ST_EMPTY;
                        end
                    end
                    default: r_state[k] <= ST_EMPTY;
                endcase
            end
        end
    end

`ifdef DEMUX_STREAM_CNT_EN
    logic [7:0] r_cnt [4];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < 4; k++) begin
                r_cnt[k] <= '0;
            end
        end else begin
            for (int k = 0; k < 4; k++) begin
                if (cnt_clr_i) begin
                    r_cnt[k] <= '0;
                end else if (w_drain[k]) begin
                    r_cnt[k] <= r_cnt[k] + 8'd1;
                end
            end
        end
    end

    always_comb begin
        cnt_o = '0;
        for (int k = 0; k < 4; k++) begin
            cnt_o[k*8 +: 8] = r_cnt[k];
        end
    end
`endif

endmodule

// File: tb/tb_demux_stream.sv
// tb/tb_demux_stream.sv - self-checking bench for demux_stream against a channel-occupancy model.
module tb_demux_stream;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic [7:0]  data_i = '0;
    logic [1:0]  sel_i = '0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [31:0] q_o;
    logic [3:0]  valid_o;
    logic [3:0]  ready_i = '0;
    logic        cnt_clr_i = 1'b0;
`ifdef DEMUX_STREAM_CNT_EN
    logic [31:0] cnt_o;
`endif

    int checks = 0;
    int errors = 0;

    // Model: number of beats buffered per channel, last beat loaded per channel, drain counts.
    int         m_occ  [4];
    logic [7:0] m_last [4];
    logic [7:0] m_cnt  [4];

    always #5 clk_i = ~clk_i;

    demux_stream #(.WIDTH(8)) dut (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .data_i  (data_i),
        .sel_i   (sel_i),
        .valid_i (valid_i),
        .ready_o (ready_o),
        .q_o     (q_o),
        .valid_o (valid_o),
        .ready_i (ready_i)
`ifdef DEMUX_STREAM_CNT_EN
        ,
        .cnt_clr_i (cnt_clr_i),
        .cnt_o     (cnt_o)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] exp_q();
        return {m_last[3], m_last[2], m_last[1], m_last[0]};
    endfunction

    function automatic logic [3:0] exp_valid();
        logic [3:0] v;
        for (int k = 0; k < 4; k++) v[k] = (m_occ[k] > 0);
        return v;
    endfunction

    function automatic logic [31:0] exp_cnt();
        return {m_cnt[3], m_cnt[2], m_cnt[1], m_cnt[0]};
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 4; k++) begin
            m_occ[k]  = 0;
            m_last[k] = 8'h00;
            m_cnt[k]  = 8'h00;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_valid"}, {28'h0, valid_o}, {28'h0, exp_valid()});
        chk({tag, "_q"}, q_o, exp_q());
`ifdef DEMUX_STREAM_CNT_EN
        chk({tag, "_cnt"}, cnt_o, exp_cnt());
`endif
    endtask

    // One clock cycle: drive, check ready_o, clock, update the model, check outputs.
    task automatic step(input logic v, input logic [1:0] s, input logic [7:0] d,
                        input logic [3:0] r, input logic clr, input string tag);
        logic exp_rdy;
        valid_i   = v;
        sel_i     = s;
        data_i    = d;
        ready_i   = r;
        cnt_clr_i = clr;
        #1;
        exp_rdy = (m_occ[s] == 0) || r[s];
        chk({tag, "_ready"}, {31'h0, ready_o}, {31'h0, exp_rdy});
        @(posedge clk_i);
        #1;
        for (int k = 0; k < 4; k++) begin
            if (m_occ[k] > 0 && r[k]) begin
                m_occ[k]--;
                if (!clr) m_cnt[k] = m_cnt[k] + 8'd1;
            end
            if (clr) m_cnt[k] = 8'h00;
        end
        if (v && exp_rdy) begin
            m_occ[s]++;
            m_last[s] = d;
        end
        check_outputs(tag);
    endtask

    task automatic do_reset();
        rst_n_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 4'h0;
        cnt_clr_i = 1'b0;
        model_reset();
        repeat (2) @(posedge clk_i);
        #1;
        rst_n_i = 1'b1;
        #1;
    endtask

    initial begin
        model_reset();
        do_reset();

        // Reset state
        chk("rst_valid", {28'h0, valid_o}, 32'h0);
        chk("rst_q", q_o, 32'h0);
        for (int s = 0; s < 4; s++) begin
            sel_i = 2'(s);
            #1;
            chk("rst_ready", {31'h0, ready_o}, 32'h1);
        end

        // Test 1: beat to stalled channel 2
        step(1'b1, 2'd2, 8'hA5, 4'b0000, 1'b0, "t1");
        chk("t1_valid_c", {28'h0, valid_o}, 32'h4);
        chk("t1_q2_c", {24'h0, q_o[23:16]}, 32'hA5);
        valid_i = 1'b1; sel_i = 2'd2; ready_i = 4'b0000;
        #1;
        chk("t1_ready_sel2", {31'h0, ready_o}, 32'h0);
        sel_i = 2'd0;
        #1;
        chk("t1_ready_sel0", {31'h0, ready_o}, 32'h1);

        // Test 2: channel 0 passes while channel 2 is blocked
        step(1'b1, 2'd0, 8'h11, 4'b0000, 1'b0, "t2");
        chk("t2_valid_c", {28'h0, valid_o}, 32'h5);
        chk("t2_q2_c", {24'h0, q_o[23:16]}, 32'hA5);
        chk("t2_q0_c", {24'h0, q_o[7:0]}, 32'h11);

        // Test 3: full-throughput stream into channel 1
        for (int i = 1; i <= 8; i++) begin
            step(1'b1, 2'd1, 8'(i), 4'b0010, 1'b0, "t3");
            chk("t3_q1_c", {24'h0, q_o[15:8]}, i);
            chk("t3_v1_c", {31'h0, valid_o[1]}, 32'h1);
        end

        // Test 4: back-to-back reload on channel 3
        step(1'b1, 2'd3, 8'hC3, 4'b0000, 1'b0, "t4a");
        step(1'b1, 2'd3, 8'h3C, 4'b1000, 1'b0, "t4b");
        chk("t4_v3_c", {31'h0, valid_o[3]}, 32'h1);
        chk("t4_q3_c", {24'h0, q_o[31:24]}, 32'h3C);

        // Test 5: asynchronous reset with all channels full
        step(1'b1, 2'd1, 8'h77, 4'b0000, 1'b0, "t5fill");
        chk("t5_allfull", {28'h0, valid_o}, 32'hF);
        #2;
        rst_n_i = 1'b0;
        #1;
        chk("t5_async_valid", {28'h0, valid_o}, 32'h0);
        chk("t5_async_q", q_o, 32'h0);
        model_reset();
        valid_i = 1'b0;
        @(posedge clk_i);
        #3;
        rst_n_i = 1'b1;
        ready_i = 4'h0;
        for (int s = 0; s < 4; s++) begin
            sel_i = 2'(s);
            #1;
            chk("t5_ready_after", {31'h0, ready_o}, 32'h1);
        end

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            logic [3:0] r;
            r = 4'($urandom) | 4'($urandom);
            step(1'($urandom_range(0, 3) != 0), 2'($urandom), 8'($urandom), r, 1'b0, "rnd");
        end

`ifdef DEMUX_STREAM_CNT_EN
        // Test 6: drain counters, wrap and clear priority
        do_reset();
        for (int i = 0; i < 256; i++) step(1'b1, 2'd0, 8'(i), 4'b0001, 1'b0, "t6c0");
        step(1'b0, 2'd0, 8'h00, 4'b0001, 1'b0, "t6c0e");
        for (int i = 0; i < 3; i++) step(1'b1, 2'd1, 8'(i), 4'b0010, 1'b0, "t6c1");
        step(1'b0, 2'd1, 8'h00, 4'b0010, 1'b0, "t6c1e");
        chk("t6_cnt_c", cnt_o, 32'h0000_0300);
        step(1'b1, 2'd1, 8'h5A, 4'b0000, 1'b0, "t6ld");
        step(1'b0, 2'd1, 8'h00, 4'b0010, 1'b1, "t6clr");
        chk("t6_clr_c", cnt_o, 32'h0);
        cnt_clr_i = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
